// File: rtl/bpd_pkg.sv
// Shared constants and entry layout for the branch outcome buffer of the
// fetch-stage tournament predictor.
package bpd_pkg;

  localparam int GHR_W = 12;
  localparam int LH_W  = 10;

  typedef struct packed {
    logic [63:0]      pc;
    logic [GHR_W-1:0] bhr;
    logic [LH_W-1:0]  lochist;
    logic             pred;
    logic             chwe;
    logic             chud;
    logic             brdir;
    logic             valid;
    logic             resolved;
  } bob_entry_t;

  // Global history as it should have evolved had the branch been predicted right.
  function automatic logic [GHR_W-1:0] shift_bhr(input logic [GHR_W-1:0] bhr,
                                                 input logic             dir);
    return {bhr[GHR_W-2:0], dir};
  endfunction

endpackage

// File: rtl/bpd_bob_if.sv
// Allocation, resolution, retire and recovery signals of the branch outcome
// buffer; slave is the buffer itself, master is the predictor/execute side.
interface bpd_bob_if #(
  parameter int LOG_DEPTH = 4
);
  import bpd_pkg::*;

  logic                   flush_all_i;
  logic                   alloc_valid_i;
  logic                   alloc_ready_o;
  logic [63:0]            alloc_pc_i;
  logic [GHR_W-1:0]       alloc_bhr_i;
  logic [LH_W-1:0]        alloc_lochist_i;
  logic                   alloc_pred_i;
  logic                   alloc_chwe_i;
  logic                   alloc_chud_i;
  logic [LOG_DEPTH-1:0]   alloc_tag_o;
  logic                   res_valid_i;
  logic [LOG_DEPTH-1:0]   res_tag_i;
  logic                   res_brdir_i;
  logic                   rt_ud_o;
  logic                   rt_brdir_o;
  logic [63:0]            rt_pc_o;
  logic [GHR_W-1:0]       rt_bhr_o;
  logic [LH_W-1:0]        rt_lochist_o;
  logic                   rt_ch_we_o;
  logic                   rt_ch_dir_o;
  logic                   rec_valid_o;
  logic [GHR_W-1:0]       rec_bhr_o;
  logic [LH_W-1:0]        rec_lochist_o;
  logic [LOG_DEPTH:0]     count_o;

  modport slave (
    input  flush_all_i, alloc_valid_i, alloc_pc_i, alloc_bhr_i, alloc_lochist_i,
           alloc_pred_i, alloc_chwe_i, alloc_chud_i, res_valid_i, res_tag_i, res_brdir_i,
    output alloc_ready_o, alloc_tag_o, rt_ud_o, rt_brdir_o, rt_pc_o, rt_bhr_o,
           rt_lochist_o, rt_ch_we_o, rt_ch_dir_o, rec_valid_o, rec_bhr_o,
           rec_lochist_o, count_o
  );

  modport master (
    output flush_all_i, alloc_valid_i, alloc_pc_i, alloc_bhr_i, alloc_lochist_i,
           alloc_pred_i, alloc_chwe_i, alloc_chud_i, res_valid_i, res_tag_i, res_brdir_i,
    input  alloc_ready_o, alloc_tag_o, rt_ud_o, rt_brdir_o, rt_pc_o, rt_bhr_o,
           rt_lochist_o, rt_ch_we_o, rt_ch_dir_o, rec_valid_o, rec_bhr_o,
           rec_lochist_o, count_o
  );

endinterface

// File: rtl/bpd_bob_ptr.sv
// Head/tail pointer pair with wrap bits: occupancy, full/empty, and the tail
// rewind used when a mispredict squashes all younger entries.
module bpd_bob_ptr #(
  parameter int LOG_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 inc_head,
  input  logic                 inc_tail,
  input  logic                 squash,
  input  logic [LOG_DEPTH-1:0] squash_tag,
  output logic [LOG_DEPTH-1:0] head_idx,
  output logic [LOG_DEPTH-1:0] tail_idx,
  output logic [LOG_DEPTH:0]   count,
  output logic                 full,
  output logic                 empty
);

  localparam int PW = LOG_DEPTH + 1;
  localparam logic [PW-1:0] PTR_ONE = {{LOG_DEPTH{1'b0}}, 1'b1};

  logic [PW-1:0]        head_r;
  logic [PW-1:0]        tail_r;
  logic [PW-1:0]        tail_nxt_s;
  logic [PW-1:0]        squash_tail_s;
  logic [LOG_DEPTH-1:0] age_s;

  // Rewinding from head by the squashed entry's age keeps the wrap bit correct.
  always_comb begin
    age_s         = squash_tag - head_r[LOG_DEPTH-1:0];
    squash_tail_s = head_r + {1'b0, age_s} + PTR_ONE;
    if (squash) begin
      tail_nxt_s = squash_tail_s;
    end else if (inc_tail) begin
      tail_nxt_s = tail_r + PTR_ONE;
    end else begin
      tail_nxt_s = tail_r;
    end
  end

  // Pointer registers.
  always_ff @(posedge clock or posedge reset_n) begin
    if (reset_n) begin
      head_r <= {PW{1'b0}};
      tail_r <= {PW{1'b0}};
    end else if (clear) begin
      head_r <= {PW{1'b0}};
      tail_r <= {PW{1'b0}};
    end else begin
      head_r <= head_r + {{LOG_DEPTH{1'b0}}, inc_head};
      tail_r <= tail_nxt_s;
    end
  end

  assign head_idx = head_r[LOG_DEPTH-1:0];
  assign tail_idx = tail_r[LOG_DEPTH-1:0];
  assign count    = tail_r - head_r;
  assign empty    = (head_r == tail_r);
  assign full     = (head_idx == tail_idx) && (head_r[LOG_DEPTH] != tail_r[LOG_DEPTH]);

endmodule

// File: rtl/bpd_bob.sv
// Branch outcome buffer: records predictor context per in-flight branch,
// takes out-of-order resolutions, retires in order and signals BHR recovery.
module bpd_bob
  import bpd_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int LOG_DEPTH = 4
) (
  input logic      clock,
  input logic      reset_n,
  bpd_bob_if.slave bob
);

  bob_entry_t           ent_r [DEPTH];
  logic [LOG_DEPTH-1:0] head_idx_s;
  logic [LOG_DEPTH-1:0] tail_idx_s;
  logic [LOG_DEPTH-1:0] res_age_s;
  logic [LOG_DEPTH:0]   count_s;
  logic                 full_s;
  logic                 empty_s;
  logic                 res_hit_s;
  logic                 mispred_s;
  logic                 alloc_fire_s;
  logic                 retire_s;
  logic [DEPTH-1:0]     younger_s;

  assign res_hit_s    = bob.res_valid_i && !bob.flush_all_i &&
                        ent_r[bob.res_tag_i].valid && !ent_r[bob.res_tag_i].resolved;
  assign mispred_s    = res_hit_s && (bob.res_brdir_i != ent_r[bob.res_tag_i].pred);
  // A same-cycle mispredict makes any new allocation wrong-path.
  assign alloc_fire_s = bob.alloc_valid_i && !full_s && !mispred_s && !bob.flush_all_i;
  assign retire_s     = !empty_s && !bob.flush_all_i &&
                        ent_r[head_idx_s].valid && ent_r[head_idx_s].resolved;
  assign res_age_s    = bob.res_tag_i - head_idx_s;

  bpd_bob_ptr #(.LOG_DEPTH(LOG_DEPTH)) u_ptr (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (bob.flush_all_i),
    .inc_head   (retire_s),
    .inc_tail   (alloc_fire_s),
    .squash     (mispred_s),
    .squash_tag (bob.res_tag_i),
    .head_idx   (head_idx_s),
    .tail_idx   (tail_idx_s),
    .count      (count_s),
    .full       (full_s),
    .empty      (empty_s)
  );

  // Marks entries allocated after the resolving branch, by age from head.
  always_comb begin
    younger_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      younger_s[i] = (LOG_DEPTH'(i) - head_idx_s) > res_age_s;
    end
  end

  // Entry array: allocate at tail, record resolutions, retire head, squash younger.
  always_ff @(posedge clock or posedge reset_n) begin
    if (reset_n) begin
      for (int i = 0; i < DEPTH; i++) ent_r[i] <= '0;
    end else if (bob.flush_all_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_r[i].valid    <= 1'b0;
        ent_r[i].resolved <= 1'b0;
      end
    end else begin
      if (alloc_fire_s) begin
        ent_r[tail_idx_s] <= '{pc: bob.alloc_pc_i, bhr: bob.alloc_bhr_i,
                               lochist: bob.alloc_lochist_i, pred: bob.alloc_pred_i,
                               chwe: bob.alloc_chwe_i, chud: bob.alloc_chud_i,
                               brdir: 1'b0, valid: 1'b1, resolved: 1'b0};
      end
      if (res_hit_s) begin
        ent_r[bob.res_tag_i].brdir    <= bob.res_brdir_i;
        ent_r[bob.res_tag_i].resolved <= 1'b1;
      end
      if (retire_s) begin
        ent_r[head_idx_s].valid <= 1'b0;
      end
      if (mispred_s) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (younger_s[i]) ent_r[i].valid <= 1'b0;
        end
      end
    end
  end

  // Retire and recovery outputs: pulses plus payload held until the next event.
  always_ff @(posedge clock or posedge reset_n) begin
    if (reset_n) begin
      bob.rt_ud_o       <= 1'b0;
      bob.rt_brdir_o    <= 1'b0;
      bob.rt_pc_o       <= 64'h0;
      bob.rt_bhr_o      <= {GHR_W{1'b0}};
      bob.rt_lochist_o  <= {LH_W{1'b0}};
      bob.rt_ch_we_o    <= 1'b0;
      bob.rt_ch_dir_o   <= 1'b0;
      bob.rec_valid_o   <= 1'b0;
      bob.rec_bhr_o     <= {GHR_W{1'b0}};
      bob.rec_lochist_o <= {LH_W{1'b0}};
    end else begin
      bob.rt_ud_o     <= retire_s;
      bob.rec_valid_o <= mispred_s;
      if (retire_s) begin
        bob.rt_brdir_o   <= ent_r[head_idx_s].brdir;
        bob.rt_pc_o      <= ent_r[head_idx_s].pc;
        bob.rt_bhr_o     <= ent_r[head_idx_s].bhr;
        bob.rt_lochist_o <= ent_r[head_idx_s].lochist;
        bob.rt_ch_we_o   <= ent_r[head_idx_s].chwe;
        bob.rt_ch_dir_o  <= ent_r[head_idx_s].brdir ^ ent_r[head_idx_s].chud;
      end
      if (mispred_s) begin
        bob.rec_bhr_o     <= shift_bhr(ent_r[bob.res_tag_i].bhr, bob.res_brdir_i);
        bob.rec_lochist_o <= ent_r[bob.res_tag_i].lochist;
      end
    end
  end

  assign bob.alloc_ready_o = !full_s;
  assign bob.alloc_tag_o   = tail_idx_s;
  assign bob.count_o       = count_s;

endmodule

// File: tb/tb_bpd_bob.sv
// Directed bench for bpd_bob: a table of per-cycle vectors with hand-computed
// expectations, then hand-written wrap, flush and mid-fill reset sequences.
module tb_bpd_bob;
  import bpd_pkg::*;

  typedef struct packed {
    logic        rst, flush, av;
    logic [63:0] pc;
    logic [11:0] bhr;
    logic [9:0]  lh;
    logic        pred, chwe, chud, rv;
    logic [3:0]  rtag;
    logic        rdir;
    logic        e_ready;
    logic [3:0]  e_tag;
    logic [4:0]  e_count;
    logic        e_rt;
    logic [63:0] e_pc;
    logic [11:0] e_bhr;
    logic [9:0]  e_lh;
    logic        e_brdir, e_chwe, e_chdir, e_rec;
    logic [11:0] e_rbhr;
    logic [9:0]  e_rlh;
  } vec_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  int   checks  = 0;
  int   errors  = 0;

  bpd_bob_if #(.LOG_DEPTH(4)) bif ();

  bpd_bob #(.DEPTH(16), .LOG_DEPTH(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bob     (bif.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    bif.flush_all_i = 1'b0; bif.alloc_valid_i = 1'b0; bif.alloc_pc_i = 64'h0;
    bif.alloc_bhr_i = 12'h0; bif.alloc_lochist_i = 10'h0; bif.alloc_pred_i = 1'b0;
    bif.alloc_chwe_i = 1'b0; bif.alloc_chud_i = 1'b0; bif.res_valid_i = 1'b0;
    bif.res_tag_i = 4'h0; bif.res_brdir_i = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_alloc(input logic [63:0] pc, input logic [11:0] bhr);
    idle_in();
    bif.alloc_valid_i = 1'b1; bif.alloc_pc_i = pc; bif.alloc_bhr_i = bhr;
    bif.alloc_lochist_i = bhr[9:0]; bif.alloc_pred_i = 1'b1;
    step();
  endtask

  task automatic do_res(input logic [3:0] tag, input logic dir);
    idle_in();
    bif.res_valid_i = 1'b1; bif.res_tag_i = tag; bif.res_brdir_i = dir;
    step();
  endtask

  function automatic vec_t blank();
    vec_t v;
    v = '0;
    v.e_ready = 1'b1;
    return v;
  endfunction

  function automatic vec_t with_rt(vec_t vin, logic [63:0] pc, logic [11:0] bhr, logic [9:0] lh,
                                   logic brdir, logic chwe, logic chdir);
    vec_t v;
    v = vin;
    v.e_rt = 1'b1; v.e_pc = pc; v.e_bhr = bhr; v.e_lh = lh;
    v.e_brdir = brdir; v.e_chwe = chwe; v.e_chdir = chdir;
    return v;
  endfunction

  initial begin
    vec_t v;
    vec_t vq[$];

    idle_in();
    // Fill to full, then a 17th alloc that must be dropped.
    v = blank(); v.rst = 1'b1; vq.push_back(v);
    for (int i = 0; i < 16; i++) begin
      v = blank(); v.av = 1'b1; v.pc = 64'h1000 + 64'(4 * i);
      v.bhr = 12'(i); v.lh = 10'(i); v.pred = 1'b1;
      v.e_ready = (i < 15); v.e_tag = 4'(i + 1); v.e_count = 5'(i + 1);
      vq.push_back(v);
    end
    v = blank(); v.av = 1'b1; v.pc = 64'hDEAD; v.e_ready = 1'b0; v.e_count = 5'd16;
    vq.push_back(v);
    // Drain in order; vector 1 also tries to allocate while still full.
    for (int j = 0; j < 16; j++) begin
      v = blank(); v.rv = 1'b1; v.rtag = 4'(j); v.rdir = 1'b1;
      if (j == 1) begin v.av = 1'b1; v.pc = 64'hBAD0; end
      v.e_ready = (j >= 1); v.e_count = 5'(16 - j);
      if (j >= 1) v = with_rt(v, 64'h1000 + 64'(4 * (j - 1)), 12'(j - 1), 10'(j - 1),
                              1'b1, 1'b0, 1'b1);
      vq.push_back(v);
    end
    v = with_rt(blank(), 64'h103C, 12'd15, 10'd15, 1'b1, 1'b0, 1'b1); vq.push_back(v);
    v = blank(); vq.push_back(v);
    // Single correct branch: retire pulse two cycles after its resolve.
    v = blank(); v.av = 1'b1; v.pc = 64'h1000; v.bhr = 12'hABC; v.lh = 10'h155;
    v.pred = 1'b1; v.chwe = 1'b1; v.e_tag = 4'd1; v.e_count = 5'd1; vq.push_back(v);
    v = blank(); v.rv = 1'b1; v.rtag = 4'd0; v.rdir = 1'b1; v.e_tag = 4'd1; v.e_count = 5'd1;
    vq.push_back(v);
    v = with_rt(blank(), 64'h1000, 12'hABC, 10'h155, 1'b1, 1'b1, 1'b1); v.e_tag = 4'd1;
    vq.push_back(v);
    v = blank(); v.e_tag = 4'd1; vq.push_back(v);
    // Mispredict at tag 2 with a same-cycle alloc; later resolves are ignored.
    v = blank(); v.rst = 1'b1; vq.push_back(v);
    for (int i = 0; i < 6; i++) begin
      v = blank(); v.av = 1'b1; v.pc = 64'h2000 + 64'(4 * i); v.pred = 1'b1;
      v.bhr = (i == 2) ? 12'h0F3 : 12'(i); v.lh = (i == 2) ? 10'h2A2 : 10'(i);
      v.e_tag = 4'(i + 1); v.e_count = 5'(i + 1);
      vq.push_back(v);
    end
    v = blank(); v.rv = 1'b1; v.rtag = 4'd2; v.rdir = 1'b0; v.av = 1'b1; v.pc = 64'hBEEF;
    v.pred = 1'b1; v.e_tag = 4'd3; v.e_count = 5'd3;
    v.e_rec = 1'b1; v.e_rbhr = 12'h1E6; v.e_rlh = 10'h2A2; vq.push_back(v);
    v = blank(); v.rv = 1'b1; v.rtag = 4'd3; v.rdir = 1'b1; v.e_tag = 4'd3; v.e_count = 5'd3;
    vq.push_back(v);
    v = blank(); v.rv = 1'b1; v.rtag = 4'd5; v.rdir = 1'b0; v.e_tag = 4'd3; v.e_count = 5'd3;
    vq.push_back(v);
    // Out-of-order resolves 2,1,0 retire in order on consecutive cycles.
    v = blank(); v.rst = 1'b1; vq.push_back(v);
    for (int i = 0; i < 3; i++) begin
      v = blank(); v.av = 1'b1; v.pc = 64'h3000 + 64'(4 * i); v.bhr = 12'h100 + 12'(i);
      v.lh = 10'(i); v.pred = 1'b1; v.chwe = i[0]; v.chud = 1'b1;
      v.e_tag = 4'(i + 1); v.e_count = 5'(i + 1);
      vq.push_back(v);
    end
    for (int i = 2; i >= 0; i--) begin
      v = blank(); v.rv = 1'b1; v.rtag = 4'(i); v.rdir = 1'b1; v.e_tag = 4'd3; v.e_count = 5'd3;
      vq.push_back(v);
    end
    for (int i = 0; i < 3; i++) begin
      v = with_rt(blank(), 64'h3000 + 64'(4 * i), 12'h100 + 12'(i), 10'(i), 1'b1, i[0], 1'b0);
      v.e_tag = 4'd3; v.e_count = 5'(2 - i);
      vq.push_back(v);
    end
    v = blank(); v.e_tag = 4'd3; vq.push_back(v);

    foreach (vq[k]) begin
      v = vq[k];
      reset_n = v.rst;
      bif.flush_all_i = v.flush; bif.alloc_valid_i = v.av; bif.alloc_pc_i = v.pc;
      bif.alloc_bhr_i = v.bhr; bif.alloc_lochist_i = v.lh; bif.alloc_pred_i = v.pred;
      bif.alloc_chwe_i = v.chwe; bif.alloc_chud_i = v.chud; bif.res_valid_i = v.rv;
      bif.res_tag_i = v.rtag; bif.res_brdir_i = v.rdir;
      step();
      chk($sformatf("v%0d_ready", k), 64'(bif.alloc_ready_o), 64'(v.e_ready));
      chk($sformatf("v%0d_tag", k), 64'(bif.alloc_tag_o), 64'(v.e_tag));
      chk($sformatf("v%0d_count", k), 64'(bif.count_o), 64'(v.e_count));
      chk($sformatf("v%0d_rt_ud", k), 64'(bif.rt_ud_o), 64'(v.e_rt));
      chk($sformatf("v%0d_rec_valid", k), 64'(bif.rec_valid_o), 64'(v.e_rec));
      if (v.e_rt) begin
        chk($sformatf("v%0d_rt_pc", k), bif.rt_pc_o, v.e_pc);
        chk($sformatf("v%0d_rt_bhr", k), 64'(bif.rt_bhr_o), 64'(v.e_bhr));
        chk($sformatf("v%0d_rt_lochist", k), 64'(bif.rt_lochist_o), 64'(v.e_lh));
        chk($sformatf("v%0d_rt_brdir", k), 64'(bif.rt_brdir_o), 64'(v.e_brdir));
        chk($sformatf("v%0d_rt_ch_we", k), 64'(bif.rt_ch_we_o), 64'(v.e_chwe));
        chk($sformatf("v%0d_rt_ch_dir", k), 64'(bif.rt_ch_dir_o), 64'(v.e_chdir));
      end
      if (v.e_rec) begin
        chk($sformatf("v%0d_rec_bhr", k), 64'(bif.rec_bhr_o), 64'(v.e_rbhr));
        chk($sformatf("v%0d_rec_lochist", k), 64'(bif.rec_lochist_o), 64'(v.e_rlh));
      end
    end

    // Wrap: move head to 14, allocate 14,15,0,1 and mispredict at 15.
    reset_n = 1'b1; idle_in(); step(); reset_n = 1'b0;
    for (int i = 0; i < 14; i++) do_alloc(64'h4000 + 64'(4 * i), 12'(i));
    for (int i = 0; i < 14; i++) do_res(4'(i), 1'b1);
    idle_in();
    for (int c = 0; c < 40 && bif.count_o != 5'd0; c++) step();
    chk("wrap_drain_count", 64'(bif.count_o), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wrap_tag%0d", i), 64'(bif.alloc_tag_o), 64'((14 + i) % 16));
      do_alloc(64'h5000 + 64'(4 * i), (i == 1) ? 12'h7C1 : 12'h011);
    end
    chk("wrap_count4", 64'(bif.count_o), 64'd4);
    do_res(4'd15, 1'b0);
    chk("wrap_sq_count", 64'(bif.count_o), 64'd2);
    chk("wrap_sq_tag", 64'(bif.alloc_tag_o), 64'd0);
    chk("wrap_rec_valid", 64'(bif.rec_valid_o), 64'd1);
    chk("wrap_rec_bhr", 64'(bif.rec_bhr_o), 64'hF82);
    do_alloc(64'h5100, 12'h022);
    chk("wrap_post_tag", 64'(bif.alloc_tag_o), 64'd1);
    chk("wrap_post_count", 64'(bif.count_o), 64'd3);

    // Flush beats a same-cycle mispredict resolve and alloc.
    idle_in();
    bif.flush_all_i = 1'b1; bif.res_valid_i = 1'b1; bif.res_tag_i = 4'd14;
    bif.res_brdir_i = 1'b0; bif.alloc_valid_i = 1'b1; bif.alloc_pc_i = 64'h6666;
    step();
    chk("flush_count", 64'(bif.count_o), 64'd0);
    chk("flush_rec_valid", 64'(bif.rec_valid_o), 64'd0);
    chk("flush_rt_ud", 64'(bif.rt_ud_o), 64'd0);
    chk("flush_ready", 64'(bif.alloc_ready_o), 64'd1);
    do_res(4'd14, 1'b0);
    chk("flush_stale_rec", 64'(bif.rec_valid_o), 64'd0);
    chk("flush_stale_count", 64'(bif.count_o), 64'd0);

    // Reset while a retire pulse is visible clears outputs without a clock edge.
    do_alloc(64'h6000, 12'h033);
    do_alloc(64'h6004, 12'h044);
    do_res(4'd0, 1'b1);
    idle_in(); step();
    chk("midrst_pre_rt_ud", 64'(bif.rt_ud_o), 64'd1);
    reset_n = 1'b1;
    #2;
    chk("midrst_rt_ud", 64'(bif.rt_ud_o), 64'd0);
    chk("midrst_rt_pc", bif.rt_pc_o, 64'd0);
    chk("midrst_rt_bhr", 64'(bif.rt_bhr_o), 64'd0);
    chk("midrst_rec_bhr", 64'(bif.rec_bhr_o), 64'd0);
    chk("midrst_count", 64'(bif.count_o), 64'd0);
    chk("midrst_tag", 64'(bif.alloc_tag_o), 64'd0);
    chk("midrst_ready", 64'(bif.alloc_ready_o), 64'd1);
    step();
    reset_n = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
